// File: rtl/data_pack_gearbox.sv
// data_pack_gearbox: packs RATIO=DO_WIDTH/DI_WIDTH narrow words into one wide word.
// Ports: clk, reset (async, active-high);
//   input stream  din/din_valid/din_last -> din_ready;
//   output stream dout/dout_cnt/dout_last/dout_valid <- dout_ready.
// The first accepted word lands in the MS lane. dout_cnt is the number of valid lanes.
// Optional idle-timeout flush of partial words is enabled by defining DPACK_TIMEOUT_EN.
module data_pack_gearbox #(
  parameter int DI_WIDTH = 32,
  parameter int DO_WIDTH = 64,
  parameter int IDLE_TIMEOUT = 16,
  localparam int RATIO = DO_WIDTH / DI_WIDTH,
  localparam int CW = $clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DI_WIDTH-1:0] din,
  input  logic                din_valid,
  input  logic                din_last,
  output logic                din_ready,
  output logic [DO_WIDTH-1:0] dout,
  output logic [CW-1:0]       dout_cnt,
  output logic                dout_last,
  output logic                dout_valid,
  input  logic                dout_ready
);
  if (RATIO < 2 || DO_WIDTH % DI_WIDTH != 0 || IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_param
    $error("data_pack_gearbox: illegal parameters");
  end
  logic [DO_WIDTH-1:0] asm_q, pk;
  logic [CW-1:0] asm_cnt, fill;
  logic pend, pend_last, accept, out_free, close, load, tmo;
  assign din_ready = !pend;
  assign accept = din_valid && !pend;
  assign out_free = !dout_valid || dout_ready;
  // Unused lanes of the assembly are always zero, so OR-ing the shifted word places it.
  assign pk = accept ? asm_q | ((DO_WIDTH'(din) << (DO_WIDTH - DI_WIDTH)) >> (DI_WIDTH * asm_cnt)) : asm_q;
  assign fill = asm_cnt + CW'(accept);
  assign close = !pend && ((accept && (din_last || asm_cnt == CW'(RATIO - 1))) || tmo);
  // A pending word has priority; it is the only thing that can load while pend is set.
  assign load = pend ? out_free : close && out_free;
`ifdef DPACK_TIMEOUT_EN
  logic [15:0] idle;
  assign tmo = !pend && asm_cnt != '0 && !accept && idle == 16'(IDLE_TIMEOUT);
  always_ff @(posedge clk or posedge reset)
    if (reset) idle <= '0;
    else if (accept || tmo) idle <= '0;
    else if (asm_cnt != '0 && !pend) idle <= idle + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      asm_q <= '0;
      asm_cnt <= '0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      dout <= '0;
      dout_cnt <= '0;
      dout_last <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (load) begin
        dout <= pend ? asm_q : pk;
        dout_cnt <= pend ? asm_cnt : fill;
        dout_last <= pend ? pend_last : accept && din_last;
        dout_valid <= 1'b1;
      end else if (dout_ready) dout_valid <= 1'b0;
      if (load) begin
        asm_q <= '0;
        asm_cnt <= '0;
        pend <= 1'b0;
      end else if (close) begin
        asm_q <= pk;
        asm_cnt <= fill;
        pend <= 1'b1;
        pend_last <= accept && din_last;
      end else if (accept) begin
        asm_q <= pk;
        asm_cnt <= fill;
      end
    end
endmodule

// File: tb/tb_data_pack_gearbox.sv
// tb_data_pack_gearbox: directed and randomized checks of data_pack_gearbox against a packet-level model.
module tb_data_pack_gearbox;
  localparam int R = 2;
  logic clk = 0, reset = 1;
  logic [31:0] din = 0;
  logic din_valid = 0, din_last = 0, din_ready;
  logic [63:0] dout;
  logic [1:0] dout_cnt;
  logic dout_last, dout_valid, dout_ready = 1;
  logic [15:0] b_din = 0;
  logic b_valid = 0, b_last = 0, b_ready;
  logic [63:0] b_dout;
  logic [2:0] b_cnt;
  logic b_dlast, b_dvalid;
  typedef struct {logic [63:0] w; int cnt; bit last;} beat_t;
  beat_t exp_q[$];
  logic [31:0] cur[$];
  int n_chk = 0, n_fail = 0;
  bit rnd = 0;
  logic prev_stall = 0;
  logic [67:0] prev_out = 0;
  data_pack_gearbox #(.DI_WIDTH(32), .DO_WIDTH(64), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .dout(dout), .dout_cnt(dout_cnt), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready));
  data_pack_gearbox #(.DI_WIDTH(16), .DO_WIDTH(64)) dut16 (
    .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid), .din_last(b_last),
    .din_ready(b_ready), .dout(b_dout), .dout_cnt(b_cnt), .dout_last(b_dlast),
    .dout_valid(b_dvalid), .dout_ready(1'b1));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [95:0] got, logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void close_word(bit last);
    logic [63:0] w = '0;
    foreach (cur[i]) w[63-32*i -: 32] = cur[i];
    exp_q.push_back('{w, cur.size(), last});
    cur.delete();
  endfunction
  always @(negedge clk)
    if (reset) begin
      cur.delete();
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) check("hold", {dout_valid, dout_last, dout_cnt, dout}, prev_out);
      if (dout_valid && dout_ready) begin
        check("dout_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("dout", dout, exp_q[0].w);
          check("dout_cnt", dout_cnt, exp_q[0].cnt);
          check("dout_last", dout_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_out = {dout_valid, dout_last, dout_cnt, dout};
      if (din_valid && din_ready) begin
        cur.push_back(din);
        if (din_last || cur.size() == R) close_word(din_last);
      end
    end
  task automatic push(logic [31:0] w, bit last, output int waits);
    bit ok;
    din = w;
    din_last = last;
    din_valid = 1;
    waits = 0;
    forever begin
      if (rnd) dout_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      ok = din_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (++waits > 200) begin
        check("push_timeout", waits, 0);
        break;
      end
    end
  endtask
  task automatic idle(int n);
    din_valid = 0;
    din_last = 0;
    repeat (n) begin
      if (rnd) dout_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int w;
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_cnt", dout_cnt, 0);
    check("rst_din_ready", din_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    idle(1);
    push(32'hAAAA0001, 0, w);
    push(32'hBBBB0002, 0, w);
    din_valid = 0;
    check("t1_valid", dout_valid, 1);
    check("t1_dout", dout, 64'hAAAA0001_BBBB0002);
    check("t1_cnt", dout_cnt, 2);
    check("t1_last", dout_last, 0);
    idle(1);
    check("t1_valid_drop", dout_valid, 0);
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + i, 0, w);
      check("t2_stall", w, 0);
      check("t2_beat", dout_valid, i % 2);
    end
    push(32'h12345678, 1, w);
    din_valid = 0;
    check("t3_dout", dout, 64'h12345678_00000000);
    check("t3_cnt", dout_cnt, 1);
    check("t3_last", dout_last, 1);
    idle(1);
    dout_ready = 0;
    for (int i = 0; i < 4; i++) push(32'h4000 + i, 0, w);
    check("t4_din_ready", din_ready, 0);
    check("t4_hold_a", dout, 64'h00004000_00004001);
    idle(3);
    check("t4_hold_b", dout, 64'h00004000_00004001);
    check("t4_din_ready_b", din_ready, 0);
    dout_ready = 1;
    idle(1);
    check("t4_second", dout, 64'h00004002_00004003);
    check("t4_second_valid", dout_valid, 1);
    check("t4_din_ready_c", din_ready, 1);
    idle(1);
    check("t4_drained", dout_valid, 0);
`ifdef DPACK_TIMEOUT_EN
    push(32'h55AA55AA, 0, w);
    din_valid = 0;
    w = 0;
    while (!dout_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    close_word(0);
    check("t5_latency", w, 5);
    check("t5_dout", dout, 64'h55AA55AA_00000000);
    check("t5_cnt", dout_cnt, 1);
    check("t5_last", dout_last, 0);
    idle(1);
`else
    push(32'h55AA55AA, 0, w);
    din_valid = 0;
    w = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      w += dout_valid;
    end
    check("t5_no_flush", w, 0);
    push(32'h00000066, 1, w);
    din_valid = 0;
    check("t5_dout", dout, 64'h55AA55AA_00000066);
    check("t5_last", dout_last, 1);
    idle(1);
`endif
    for (int i = 0; i < 4; i++) begin
      b_din = 16'h1111 * 16'(i + 1);
      b_last = i == 3;
      b_valid = 1;
      @(posedge clk);
      #1;
    end
    b_valid = 0;
    b_last = 0;
    check("t6_dout", b_dout, 64'h1111_2222_3333_4444);
    check("t6_cnt", b_cnt, 4);
    check("t6_last", b_dlast, 1);
    check("t6_valid", b_dvalid, 1);
    b_din = 16'hBEEF;
    b_valid = 1;
    @(posedge clk);
    #1 b_valid = 0;
    dout_ready = 0;
    for (int i = 0; i < 3; i++) push(32'h7000 + i, 0, w);
    din_valid = 0;
    #2 reset = 1;
    #1;
    check("rst_mid_valid", dout_valid, 0);
    check("rst_mid_dout", dout, 0);
    check("rst_mid_cnt", dout_cnt, 0);
    check("rst_mid_last", dout_last, 0);
    check("rst_mid_ready", din_ready, 1);
    check("rst_mid_b_valid", b_dvalid, 0);
    @(posedge clk);
    #1 reset = 0;
    dout_ready = 1;
    push(32'h8001, 0, w);
    push(32'h8002, 1, w);
    din_valid = 0;
    check("rst_next_dout", dout, 64'h00008001_00008002);
    check("rst_next_last", dout_last, 1);
    b_din = 16'hCAFE;
    b_last = 1;
    b_valid = 1;
    @(posedge clk);
    #1 b_valid = 0;
    b_last = 0;
    check("rst_next_b", b_dout, 64'hCAFE_0000_0000_0000);
    check("rst_next_b_cnt", b_cnt, 1);
    idle(1);
    rnd = 1;
    repeat (150) begin
      int len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) push($urandom, i == len - 1, w);
      idle($urandom_range(0, 3));
    end
    rnd = 0;
    dout_ready = 1;
    idle(10);
    check("drain_exp", exp_q.size(), 0);
    check("drain_cur", cur.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
